// File: rtl/ex_issue_stage.sv
// rtl/ex_issue_stage.sv - operand-resolution pipeline register ahead of the execute ALU
package alufnt;
  typedef enum logic [2:0] {
    add  = 3'd0,
    sub  = 3'd1,
    sll  = 3'd2,
    slt  = 3'd3,
    sltu = 3'd4,
    lxor = 3'd5,
    srl  = 3'd6,
    land = 3'd7
  } alu_func_t;
endpackage

module ex_issue_stage #(
  parameter int STALL_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_pc,
  input  logic [4:0]              in_rs1_idx,
  input  logic [4:0]              in_rs2_idx,
  input  logic [4:0]              in_rd_idx,
  input  logic [31:0]             in_rs1_data,
  input  logic [31:0]             in_rs2_data,
  input  logic [31:0]             in_imm,
  input  alufnt::alu_func_t       in_fn,
  input  logic                    in_op1_pc,
  input  logic                    in_op2_imm,
  input  logic                    in_rd_we,
  input  logic                    exm_we,
  input  logic [4:0]              exm_rd,
  input  logic [31:0]             exm_data,
  input  logic                    exm_is_load,
  input  logic                    wb_we,
  input  logic [4:0]              wb_rd,
  input  logic [31:0]             wb_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output alufnt::alu_func_t       out_fn,
  output logic [31:0]             out_in1,
  output logic [31:0]             out_in2,
  output logic [31:0]             out_pc,
  output logic [4:0]              out_rd_idx,
  output logic                    out_rd_we,
  output logic [31:0]             out_store_data,
  output logic [STALL_CNT_W-1:0]  stall_count
);

  logic                   r_out_valid;
  alufnt::alu_func_t      r_out_fn;
  logic [31:0]            r_out_in1, r_out_in2, r_out_pc, r_out_store_data;
  logic [4:0]             r_out_rd_idx;
  logic                   r_out_rd_we;
  logic [STALL_CNT_W-1:0] r_stall_count;

  logic [31:0] w_rs1_fwd, w_rs2_fwd;
  logic        w_hz, w_capture;

  // EX/MEM wins over WB; x0 always reads as zero regardless of producers
  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf_data,
                                      input logic ex_we, input logic [4:0] ex_rd,
                                      input logic [31:0] ex_data, input logic w_we,
                                      input logic [4:0] w_rd, input logic [31:0] w_data);
    if (idx == 5'd0)                   return 32'd0;
    else if (ex_we && (ex_rd == idx))  return ex_data;
    else if (w_we && (w_rd == idx))    return w_data;
    else                               return rf_data;
  endfunction

  always_comb begin
    w_rs1_fwd = fwd(in_rs1_idx, in_rs1_data, exm_we, exm_rd, exm_data, wb_we, wb_rd, wb_data);
    w_rs2_fwd = fwd(in_rs2_idx, in_rs2_data, exm_we, exm_rd, exm_data, wb_we, wb_rd, wb_data);
  end

  // rs2 always counts as used since its value also feeds store data
  assign w_hz = in_valid && exm_we && exm_is_load && (exm_rd != 5'd0) &&
                ((!in_op1_pc && (exm_rd == in_rs1_idx)) || (exm_rd == in_rs2_idx));

  assign in_ready  = !rst || (!w_hz && (!r_out_valid || out_ready));
  assign w_capture = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid      <= 1'b0;
      r_out_fn         <= alufnt::add;
      r_out_in1        <= 32'd0;
      r_out_in2        <= 32'd0;
      r_out_pc         <= 32'd0;
      r_out_store_data <= 32'd0;
      r_out_rd_idx     <= 5'd0;
      r_out_rd_we      <= 1'b0;
      r_stall_count    <= '0;
    end else begin
      if (flush)          r_out_valid <= 1'b0;
      else if (w_capture) r_out_valid <= 1'b1;
      else if (out_ready) r_out_valid <= 1'b0;

      if (w_capture) begin
        r_out_fn         <= in_fn;
        r_out_in1        <= in_op1_pc ? in_pc : w_rs1_fwd;
        r_out_in2        <= in_op2_imm ? in_imm : w_rs2_fwd;
        r_out_pc         <= in_pc;
        r_out_store_data <= w_rs2_fwd;
        r_out_rd_idx     <= in_rd_idx;
        r_out_rd_we      <= in_rd_we;
      end

      if (in_valid && w_hz && !flush && (r_stall_count != '1))
        r_stall_count <= r_stall_count + STALL_CNT_W'(1);
    end
  end

  assign out_valid      = r_out_valid;
  assign out_fn         = r_out_fn;
  assign out_in1        = r_out_in1;
  assign out_in2        = r_out_in2;
  assign out_pc         = r_out_pc;
  assign out_rd_idx     = r_out_rd_idx;
  assign out_rd_we      = r_out_rd_we;
  assign out_store_data = r_out_store_data;
  assign stall_count    = r_stall_count;

endmodule

// File: tb/tb_ex_issue_stage.sv
// tb/tb_ex_issue_stage.sv - vector table plus scoreboard bench for ex_issue_stage
module tb_ex_issue_stage;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_ready;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0] in_rs1_idx, in_rs2_idx, in_rd_idx;
  alufnt::alu_func_t in_fn;
  logic in_op1_pc, in_op2_imm, in_rd_we;
  logic exm_we, exm_is_load, wb_we, flush;
  logic [4:0] exm_rd, wb_rd;
  logic [31:0] exm_data, wb_data;
  logic out_valid, out_ready;
  alufnt::alu_func_t out_fn;
  logic [31:0] out_in1, out_in2, out_pc, out_store_data;
  logic [4:0] out_rd_idx;
  logic out_rd_we;
  logic [1:0] stall_count;

  ex_issue_stage #(.STALL_CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_rd_idx(in_rd_idx),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_fn(in_fn),
    .in_op1_pc(in_op1_pc), .in_op2_imm(in_op2_imm), .in_rd_we(in_rd_we),
    .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data), .exm_is_load(exm_is_load),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_fn(out_fn), .out_in1(out_in1),
    .out_in2(out_in2), .out_pc(out_pc), .out_rd_idx(out_rd_idx), .out_rd_we(out_rd_we),
    .out_store_data(out_store_data), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic [2:0]  fn;
    logic        op1pc, op2imm, rdwe;
    logic        exwe;
    logic [4:0]  exrd;
    logic [31:0] exd;
    logic        wbwe;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic [31:0] e_in1, e_in2, e_st;
  } vec_t;

  typedef struct {
    logic [2:0]  fn;
    logic [31:0] in1, in2, pc, st;
    logic [4:0]  rd;
    logic        rdwe;
  } exp_t;

  vec_t tbl[8];
  exp_t q[$];
  exp_t cur_exp;
  logic m_valid = 1'b0;
  logic [1:0] m_stall = 2'd0;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [2:0] fn, input logic op1pc,
                        input logic op2imm, input logic rdwe);
    in_pc = pc; in_rs1_idx = rs1; in_rs2_idx = rs2; in_rd_idx = rd;
    in_rs1_data = d1; in_rs2_data = d2; in_imm = imm; in_fn = alufnt::alu_func_t'(fn);
    in_op1_pc = op1pc; in_op2_imm = op2imm; in_rd_we = rdwe;
  endtask

  task automatic set_fwd(input logic exwe, input logic [4:0] exrd, input logic [31:0] exd,
                         input logic exld, input logic wbwe, input logic [4:0] wbrd,
                         input logic [31:0] wbd);
    exm_we = exwe; exm_rd = exrd; exm_data = exd; exm_is_load = exld;
    wb_we = wbwe; wb_rd = wbrd; wb_data = wbd;
  endtask

  task automatic set_exp(input logic [31:0] in1, input logic [31:0] in2, input logic [31:0] st);
    cur_exp = '{fn: in_fn, in1: in1, in2: in2, pc: in_pc, st: st, rd: in_rd_idx, rdwe: in_rd_we};
  endtask

  task automatic apply_vec(input vec_t v);
    set_in(v.pc, v.rs1, v.rs2, v.rd, v.d1, v.d2, v.imm, v.fn, v.op1pc, v.op2imm, v.rdwe);
    set_fwd(v.exwe, v.exrd, v.exd, 1'b0, v.wbwe, v.wbrd, v.wbd);
    set_exp(v.e_in1, v.e_in2, v.e_st);
  endtask

  // One clock: starts at a negedge with inputs driven, returns at the next negedge
  task automatic tick(input logic hz);
    logic rdy, pop, acc;
    #2;
    rdy = !hz && (!m_valid || out_ready);
    chk("in_ready", in_ready, rdy);
    if (m_valid && q.size() > 0) begin
      chk("out_fn", out_fn, q[0].fn);
      chk("out_in1", out_in1, q[0].in1);
      chk("out_in2", out_in2, q[0].in2);
      chk("out_pc", out_pc, q[0].pc);
      chk("out_store_data", out_store_data, q[0].st);
      chk("out_rd_idx", out_rd_idx, q[0].rd);
      chk("out_rd_we", out_rd_we, q[0].rdwe);
    end
    pop = m_valid && (flush || out_ready);
    acc = in_valid && rdy && !flush;
    @(posedge clk);
    if (pop && q.size() > 0) void'(q.pop_front());
    if (acc) q.push_back(cur_exp);
    if (flush)    m_valid = 1'b0;
    else if (acc) m_valid = 1'b1;
    else if (pop) m_valid = 1'b0;
    if (in_valid && hz && !flush && m_stall != 2'b11) m_stall = m_stall + 2'd1;
    @(negedge clk);
    chk("out_valid", out_valid, m_valid);
    chk("stall_count", stall_count, m_stall);
  endtask

  initial begin
    tbl[0] = '{32'h0,   5'd1, 5'd2, 5'd3,  32'h10,   32'h20,       32'h0, 3'd0, 1'b0, 1'b0, 1'b1,
               1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  32'h10,   32'h20,       32'h20};
    tbl[1] = '{32'h4,   5'd4, 5'd5, 5'd6,  32'h1234, 32'hFFFF0000, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1,
               1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  32'h1234, 32'hFFFF0000, 32'hFFFF0000};
    tbl[2] = '{32'h8,   5'd7, 5'd8, 5'd9,  32'h5,    32'h7,        32'h0, 3'd0, 1'b0, 1'b0, 1'b1,
               1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  32'h5,    32'h7,        32'h7};
    tbl[3] = '{32'hC,   5'd5, 5'd6, 5'd10, 32'h33,   32'h44,       32'h0, 3'd1, 1'b0, 1'b0, 1'b1,
               1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22, 32'h11,   32'h44,       32'h44};
    tbl[4] = '{32'h10,  5'd5, 5'd6, 5'd10, 32'h33,   32'h44,       32'h0, 3'd1, 1'b0, 1'b0, 1'b1,
               1'b0, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22, 32'h22,   32'h44,       32'h44};
    tbl[5] = '{32'h14,  5'd0, 5'd0, 5'd11, 32'h33,   32'h44,       32'h0, 3'd0, 1'b0, 1'b0, 1'b1,
               1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22, 32'h0,    32'h0,        32'h0};
    tbl[6] = '{32'h18,  5'd8, 5'd9, 5'd12, 32'h1,    32'h2,        32'h0, 3'd5, 1'b0, 1'b0, 1'b0,
               1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99, 32'h88,   32'h99,       32'h99};
    tbl[7] = '{32'h100, 5'd1, 5'd2, 5'd13, 32'hAA,   32'hBB,  32'hFFFFFFFC, 3'd3, 1'b1, 1'b1, 1'b0,
               1'b1, 5'd2, 32'hCC, 1'b0, 5'd0, 32'h0,  32'h100,  32'hFFFFFFFC, 32'hCC};

    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    set_in(32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    #3;
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset out_fn", out_fn, alufnt::add);
    chk("reset out_in1", out_in1, 32'h0);
    chk("reset stall_count", stall_count, 2'd0);
    chk("reset in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    // back-to-back stream, forwarding priority, operand select
    for (int i = 0; i < 8; i++) begin
      apply_vec(tbl[i]);
      in_valid = 1'b1;
      tick(1'b0);
    end
    in_valid = 1'b0;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick(1'b0);

    // load-use on rs2: one stall, then WB forwarding supplies the value
    set_in(32'h200, 5'd1, 5'd7, 5'd14, 32'h1, 32'h2, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1);
    set_fwd(1'b1, 5'd7, 32'hDEAD, 1'b1, 1'b0, 5'd0, 32'h0);
    in_valid = 1'b1;
    tick(1'b1);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd7, 32'hABCD);
    set_exp(32'h1, 32'hABCD, 32'hABCD);
    tick(1'b0);
    in_valid = 1'b0;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick(1'b0);

    // backpressure: A held for 4 cycles, B accepted on the release cycle
    set_in(32'h300, 5'd2, 5'd3, 5'd4, 32'hA1, 32'hA2, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1);
    set_exp(32'hA1, 32'hA2, 32'hA2);
    in_valid = 1'b1;
    tick(1'b0);
    set_in(32'h304, 5'd5, 5'd6, 5'd7, 32'hB1, 32'hB2, 32'h0, 3'd2, 1'b0, 1'b0, 1'b1);
    set_exp(32'hB1, 32'hB2, 32'hB2);
    out_ready = 1'b0;
    repeat (4) tick(1'b0);
    out_ready = 1'b1;
    tick(1'b0);
    in_valid = 1'b0;
    tick(1'b0);
    tick(1'b0);

    // flush with a held entry and an incoming one
    set_in(32'h400, 5'd1, 5'd2, 5'd3, 32'hC1, 32'hC2, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1);
    set_exp(32'hC1, 32'hC2, 32'hC2);
    in_valid = 1'b1;
    tick(1'b0);
    set_in(32'h404, 5'd4, 5'd5, 5'd6, 32'hF1, 32'hF2, 32'h0, 3'd1, 1'b0, 1'b0, 1'b1);
    set_exp(32'hF1, 32'hF2, 32'hF2);
    flush = 1'b1;
    tick(1'b0);
    flush = 1'b0;
    in_valid = 1'b0;
    tick(1'b0);

    // rs1 hazard, PC-selected rs1 is not a hazard, flush suppresses counting, saturation
    set_in(32'h500, 5'd3, 5'd4, 5'd8, 32'h31, 32'h41, 32'h8, 3'd0, 1'b0, 1'b1, 1'b1);
    set_fwd(1'b1, 5'd3, 32'h5555, 1'b1, 1'b0, 5'd0, 32'h0);
    in_valid = 1'b1;
    tick(1'b1);
    set_in(32'h504, 5'd3, 5'd4, 5'd8, 32'h31, 32'h41, 32'h0, 3'd0, 1'b1, 1'b0, 1'b1);
    set_exp(32'h504, 32'h41, 32'h41);
    tick(1'b0);
    set_in(32'h508, 5'd3, 5'd4, 5'd8, 32'h31, 32'h41, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1);
    flush = 1'b1;
    tick(1'b1);
    flush = 1'b0;
    tick(1'b1);
    tick(1'b1);
    set_in(32'h50C, 5'd0, 5'd0, 5'd9, 32'h5, 32'h6, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1);
    set_fwd(1'b1, 5'd0, 32'h77, 1'b1, 1'b0, 5'd0, 32'h0);
    set_exp(32'h0, 32'h0, 32'h0);
    tick(1'b0);
    in_valid = 1'b0;
    tick(1'b0);

    // operand select then asynchronous reset mid-cycle with a valid entry held
    apply_vec(tbl[7]);
    in_valid = 1'b1;
    tick(1'b0);
    in_valid = 1'b0;
    #1;
    chk("opsel out_in1", out_in1, 32'h100);
    chk("opsel out_in2", out_in2, 32'hFFFFFFFC);
    #1;
    rst = 1'b0;
    #1;
    chk("async rst out_valid", out_valid, 1'b0);
    chk("async rst out_fn", out_fn, alufnt::add);
    chk("async rst out_in1", out_in1, 32'h0);
    chk("async rst out_in2", out_in2, 32'h0);
    chk("async rst out_pc", out_pc, 32'h0);
    chk("async rst out_store_data", out_store_data, 32'h0);
    chk("async rst stall_count", stall_count, 2'd0);
    chk("async rst in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_issue_stage.md
# ex_issue_stage

Pipeline register and operand-resolution stage directly upstream of the execute ALU. Accepts one decoded RV32I instruction per cycle from decode, resolves `rs1`/`rs2` through EX/MEM and MEM/WB forwarding, selects ALU operands (register/PC, register/immediate), and presents a registered `fn`/`in1`/`in2` bundle to the ALU with a valid/ready handshake. It also holds off load-use hazards and counts stall cycles.

## Interface
- `STALL_CNT_W`, default 32, width of the saturating stall counter.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `in_valid` input 1: decode offers an instruction.
- `in_ready` output 1: stage accepts this cycle.
- `in_pc` input 32: instruction PC.
- `in_rs1_idx`, `in_rs2_idx`, `in_rd_idx` input 5 each: register indices.
- `in_rs1_data`, `in_rs2_data` input 32 each: register-file read data.
- `in_imm` input 32: sign-extended immediate.
- `in_fn` input `alufnt::alu_func_t` (3): ALU operation.
- `in_op1_pc` input 1: 1 selects PC for `in1`, else rs1.
- `in_op2_imm` input 1: 1 selects imm for `in2`, else rs2.
- `in_rd_we` input 1: instruction writes `rd`.
- `exm_we`, `exm_rd` (5), `exm_data` (32) inputs: EX/MEM producer.
- `exm_is_load` input 1: EX/MEM producer is a load; its data is not yet available.
- `wb_we`, `wb_rd` (5), `wb_data` (32) inputs: MEM/WB producer.
- `flush` input 1: kill the held and incoming instruction.
- `out_valid` output 1, `out_ready` input 1: handshake to the ALU stage.
- `out_fn` output 3, `out_in1` output 32, `out_in2` output 32: ALU operands.
- `out_pc` output 32, `out_rd_idx` output 5, `out_rd_we` output 1, `out_store_data` output 32: forwarded rs2 value, always populated.
- `stall_count` output `STALL_CNT_W`: saturating count of hazard-stall cycles.

## Operation
- Forwarding per source `s` in {rs1, rs2}: `s_idx == 0` gives 0. Otherwise, an EX/MEM match (`exm_we && exm_rd == s_idx`) gives `exm_data`. Otherwise, a WB match gives `wb_data`. Otherwise, the value is `in_sN_data`. EX/MEM has priority over WB.
- Operands:
  - `in1` is `in_pc` if `in_op1_pc`, else the forwarded rs1.
  - `in2` is `in_imm` if `in_op2_imm`, else the forwarded rs2.
  - `out_store_data` is the forwarded rs2.
- Load-use hazard `hz`: `in_valid && exm_we && exm_is_load && exm_rd != 0 && exm_rd` equals a source that is actually used. rs1 is used when `!in_op1_pc`. rs2 is used when `!in_op2_imm`, or always for store-data purposes. Define the used-rs2 rule as: rs2 is used always (conservative).
- `in_ready = !hz && (!out_valid || out_ready)`. This is combinational, and `in_ready` does not depend on `in_valid` except through `hz`.
- Capture: on `in_valid && in_ready && !flush`, all `out_*` registers load the resolved values and `out_valid` is set to 1.
- Drain: on `out_valid && out_ready` with no capture, `out_valid` goes to 0. Data registers hold their values.
- `flush` has priority over everything. The next state has `out_valid` = 0, nothing is captured, and `in_ready` is still reported normally. Decode must also drop its instruction on flush.
- `stall_count` increments when `in_valid && hz && !flush` and saturates at all-ones. It is never cleared except by reset.
- Forwarded values are resolved once, at capture. A held entry is never re-resolved. This is correct because producers only advance past this stage.

## Timing
- Reset values (immediate and asynchronous on `rst` = 0):
  - `out_valid` = 0.
  - `out_fn` = `alufnt::add`.
  - `out_in1`, `out_in2`, `out_pc`, `out_store_data` = 0.
  - `out_rd_idx` = 0, `out_rd_we` = 0.
  - `stall_count` = 0.
- `in_ready` = 1 during reset.
- Latency is 1 cycle from accept to `out_valid`. Throughput is 1 per cycle when `out_ready` is held at 1.
- Backpressure: while `out_valid && !out_ready`, all `out_*` outputs are stable and `in_ready` = 0.
- A simultaneous drain and capture in the same cycle gives back-to-back valid outputs with no bubble.
- A load-use hazard costs exactly 1 bubble once the load moves to WB, where the WB forwarding path applies.
- If reset is asserted mid-transfer, the entry is discarded and no partial output is produced.

## Test plan
- Back-to-back stream:
  - Stimulus: three `add` instructions with `out_ready` = 1.
  - Required response: `out_valid` high for 3 consecutive cycles starting 1 cycle after the first accept, with operands matching the inputs.
- Forwarding priority:
  - Stimulus: `rs1` = 5, `exm_rd` = 5 with `exm_data` = 0x11, `wb_rd` = 5 with `wb_data` = 0x22, `in_rs1_data` = 0x33.
  - Required response: `out_in1` = 0x11.
  - With EX/MEM removed: `out_in1` = 0x22.
  - With `rs1` = 0: `out_in1` = 0.
- Load-use:
  - Stimulus: `exm_is_load`, `exm_rd` = 7, incoming `rs2` = 7.
  - Required response: `in_ready` = 0 for 1 cycle and `stall_count` goes 0 to 1. The next cycle, with `wb_rd` = 7 and `wb_data` = 0xABCD, the instruction is accepted and `out_in2` = 0xABCD.
- Backpressure:
  - Stimulus: hold `out_ready` = 0 for 4 cycles with `in_valid` = 1.
  - Required response: outputs stable and `in_ready` = 0 throughout. On the cycle `out_ready` = 1, the next instruction is accepted with no bubble.
- Flush:
  - Stimulus: assert `flush` with `out_valid` = 1 and `in_valid` = 1.
  - Required response: next cycle `out_valid` = 0 and the incoming instruction never appears at the output.
- Operand select and reset:
  - Stimulus: `in_op1_pc` = 1 and `in_op2_imm` = 1 with PC = 0x100 and imm = 0xFFFFFFFC.
  - Required response: `out_in1` = 0x100 and `out_in2` = 0xFFFFFFFC.
  - Then drop `rst` asynchronously mid-cycle: `out_valid` = 0 and `out_fn` = add immediately.
